// File: rtl/i2s_clock_controller.sv
// I2S bus-clock master: generates sck/ws from clk, with stop requests finishing the current stereo frame.
// Optional frame counter enabled by defining I2S_CTRL_FRAME_COUNT_EN.
module i2s_clock_controller #(
    parameter int WIDTH     = 16,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] half_period,
    output logic                 sck,
    output logic                 ws,
    output logic                 frame_start,
    output logic                 busy
`ifdef I2S_CTRL_FRAME_COUNT_EN
    ,
    output logic [31:0]          frame_count
`endif
);

    localparam int BW = (2 * WIDTH > 2) ? $clog2(2 * WIDTH) : 1;
    localparam logic [BW-1:0] B_LAST   = BW'(2 * WIDTH - 1);
    localparam logic [BW-1:0] WS_FIRST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] WS_LAST  = BW'(2 * WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t               state;
    logic [DIV_WIDTH-1:0] hp;
    logic [DIV_WIDTH-1:0] div;
    logic [BW-1:0]        b;
    logic [BW-1:0]        b_next;
    logic                 ws_next;
    logic                 wrap;

    always_comb begin
        b_next  = (b == B_LAST) ? '0 : b + BW'(1);
        ws_next = (b_next >= WS_FIRST) && (b_next <= WS_LAST);
        wrap    = (b == B_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            hp          <= '0;
            div         <= '0;
            b           <= '0;
            sck         <= 1'b0;
            ws          <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    sck <= 1'b0;
                    ws  <= 1'b0;
                    div <= '0;
                    b   <= '0;
                    if (enable) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        frame_start <= 1'b1;
                        hp          <= (half_period == '0) ? DIV_WIDTH'(1) : half_period;
                    end
                end
                RUN, DRAIN: begin
                    if (state == RUN && !enable)
                        state <= DRAIN;
                    else if (state == DRAIN && enable)
                        state <= RUN;

                    if (div == hp - DIV_WIDTH'(1)) begin
                        div <= '0;
                        sck <= ~sck;
                        if (sck) begin
                            b  <= b_next;
                            ws <= ws_next;
                            // A re-enable landing on the draining wrap keeps the bus running seamlessly.
                            if (wrap) begin
                                if (state == RUN || enable) begin
                                    frame_start <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    ws    <= 1'b0;
                                end
                            end
                        end
                    end else begin
                        div <= div + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef I2S_CTRL_FRAME_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frame_count <= '0;
        else if (frame_start)
            frame_count <= frame_count + 32'd1;
    end
`endif

endmodule
